// File: rtl/constraint_sample_gen.sv
// Purpose: LFSR candidate generator feeding a combinational constraint checker; emits satisfying candidates.
// Latency: cand registered (first cand one cycle after start); sol_valid/sol_data one cycle after sat.
// Backpressure: HOLD freezes lanes, cand and sol_data until sol_valid & sol_ready; no new candidates meanwhile.
module constraint_sample_gen #(
   parameter int CAND_W    = 779,
   parameter int MAX_TRIES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [63:0]       seed,
   input  logic [15:0]       num_sol,
   input  logic              stop,
   output logic [CAND_W-1:0] cand,
   input  logic              sat,
   output logic              sol_valid,
   input  logic              sol_ready,
   output logic [CAND_W-1:0] sol_data,
   output logic [31:0]       tries,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   localparam int          LANES    = (CAND_W + 63) / 64;
   localparam logic [63:0] GOLDEN   = 64'h9E37_79B9_7F4A_7C15;
   localparam logic [63:0] FB_MASK  = 64'hD800_0000_0000_0000;
   // tries already holds this many failures when the final allowed one arrives
   localparam logic [31:0] LAST_TRY = 32'(MAX_TRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HOLD} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LANES*64-1:0]   r_lanes;
   logic [LANES*64-1:0]   w_lanes_step;
   logic [LANES*64-1:0]   w_lanes_seed;
   logic [CAND_W-1:0]     r_sol_data;
   logic                  r_sol_valid;
   logic [31:0]           r_tries;
   logic [15:0]           r_sol_cnt;
   logic [15:0]           r_num_sol;
   logic [15:0]           w_cnt_inc;
   logic                  r_stop_seen;
   logic                  r_done;
   logic                  r_timeout;
   logic                  w_load;
   logic                  w_capture;
   logic                  w_fail;
   logic                  w_handshake;
   logic                  w_done_nxt;
   logic                  w_timeout_nxt;

   // Per-lane Galois step and seed mixing; all-zero seeds would lock the LFSR, so force 1
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [63:0] MIX = 64'(k) * GOLDEN;
      logic [63:0] w_lane;
      logic [63:0] w_mixed;
      assign w_lane                      = r_lanes[k*64 +: 64];
      assign w_lanes_step[k*64 +: 64]    = (w_lane >> 1) ^ (w_lane[0] ? FB_MASK : 64'h0);
      assign w_mixed                     = seed ^ MIX;
      assign w_lanes_seed[k*64 +: 64]    = (w_mixed == 64'h0) ? 64'h1 : w_mixed;
   end

   assign w_cnt_inc = r_sol_cnt + 16'd1;
   assign cand      = r_lanes[CAND_W-1:0];
   assign sol_data  = r_sol_data;
   assign sol_valid = r_sol_valid;
   assign tries     = r_tries;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign timeout   = r_timeout;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes; stop beats sat, sat beats the retry limit
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_capture     = 1'b0;
      w_fail        = 1'b0;
      w_handshake   = 1'b0;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (stop) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (sat) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end else begin
               w_fail = 1'b1;
               if (r_tries == LAST_TRY) begin
                  w_timeout_nxt = 1'b1;
                  w_state_nxt   = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (r_sol_valid && sol_ready) begin
               w_handshake = 1'b1;
               if (r_stop_seen || stop || (r_num_sol != 16'd0 && w_cnt_inc == r_num_sol)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_SEARCH;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Lanes, solution capture, counters and one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lanes     <= '0;
         r_sol_data  <= '0;
         r_sol_valid <= 1'b0;
         r_tries     <= '0;
         r_sol_cnt   <= '0;
         r_num_sol   <= '0;
         r_stop_seen <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
         if (w_load)                       r_lanes <= w_lanes_seed;
         else if (w_fail || w_handshake)   r_lanes <= w_lanes_step;
         if (w_load || w_handshake)        r_tries <= '0;
         else if (w_fail && r_tries != '1) r_tries <= r_tries + 32'd1;
         if (w_load) begin
            r_sol_cnt <= '0;
            r_num_sol <= num_sol;
         end else if (w_handshake) begin
            r_sol_cnt <= w_cnt_inc;
         end
         if (w_capture) begin
            r_sol_data  <= cand;
            r_sol_valid <= 1'b1;
         end else if (w_handshake) begin
            r_sol_valid <= 1'b0;
         end
         if (w_capture)                       r_stop_seen <= 1'b0;
         else if (r_state == S_HOLD && stop)  r_stop_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_constraint_sample_gen.sv
// Directed bench for constraint_sample_gen: three-lane build (CAND_W=130) with MAX_TRIES=16.
// The bench plays the checker by driving sat per cycle; inputs change and outputs are sampled 1ns after posedge.
// Expected candidates come from a reference LFSR model plus hand-computed constants.
module tb_constraint_sample_gen;
   localparam int CW = 130;
   localparam int MT = 16;
   localparam logic [63:0] GOLD = 64'h9E37_79B9_7F4A_7C15;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [63:0]   seed;
   logic [15:0]   num_sol;
   logic          stop;
   logic [CW-1:0] cand;
   logic          sat;
   logic          sol_valid;
   logic          sol_ready;
   logic [CW-1:0] sol_data;
   logic [31:0]   tries;
   logic          busy;
   logic          done;
   logic          timeout;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] m_lane [3];

   constraint_sample_gen #(.CAND_W(CW), .MAX_TRIES(MT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_sol(num_sol),
      .stop(stop), .cand(cand), .sat(sat), .sol_valid(sol_valid), .sol_ready(sol_ready),
      .sol_data(sol_data), .tries(tries), .busy(busy), .done(done), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_step(input logic [63:0] x);
      return x[0] ? ((x >> 1) ^ 64'hD800_0000_0000_0000) : (x >> 1);
   endfunction

   function automatic logic [63:0] ref_seed(input logic [63:0] s, input int k);
      logic [63:0] v;
      v = s ^ (64'(k) * GOLD);
      return (v == 64'h0) ? 64'h1 : v;
   endfunction

   task automatic model_load(input logic [63:0] s);
      for (int k = 0; k < 3; k++) m_lane[k] = ref_seed(s, k);
   endtask

   task automatic model_adv();
      for (int k = 0; k < 3; k++) m_lane[k] = ref_step(m_lane[k]);
   endtask

   function automatic logic [CW-1:0] model_cand();
      logic [191:0] w;
      w = {m_lane[2], m_lane[1], m_lane[0]};
      return w[CW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [63:0] s, input logic [15:0] n);
      start   = 1'b1;
      seed    = s;
      num_sol = n;
      tick();
      start = 1'b0;
      model_load(s);
   endtask

   task automatic test_reset();
      n_tests++;
      if ({cand, sol_data, tries, sol_valid, busy, done, timeout} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: cand=%h sol_data=%h tries=%0d v=%b b=%b d=%b t=%b, want all 0",
                  cand, sol_data, tries, sol_valid, busy, done, timeout);
      end
   endtask

   task automatic test_stream();
      sat = 1'b1; sol_ready = 1'b1;
      start_run(64'h1234, 16'd3);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (cand !== model_cand() || sol_valid !== 1'b0 || tries !== 32'd0) begin
            n_fail++;
            $display("FAIL stream_search%0d: cand=%h v=%b tries=%0d, want cand=%h v=0 tries=0",
                     i, cand, sol_valid, tries, model_cand());
         end
         tick();
         n_tests++;
         if (sol_valid !== 1'b1 || sol_data !== model_cand() || tries !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_sol%0d: v=%b data=%h tries=%0d done=%b, want v=1 data=%h tries=0 done=0",
                     i, sol_valid, sol_data, tries, done, model_cand());
         end
         tick();
         model_adv();
      end
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || sol_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_done: done=%b busy=%b v=%b, want 1 0 0", done, busy, sol_valid);
      end
      tick();
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_done_pulse: done=%b, want 0", done);
      end
      sat = 1'b0; sol_ready = 1'b0;
   endtask

   task automatic test_timeout();
      sat = 1'b0;
      start_run(64'hCAFE, 16'd1);
      for (int i = 0; i < MT; i++) begin
         n_tests++;
         if (cand !== model_cand() || tries !== 32'(i) || timeout !== 1'b0 || busy !== 1'b1 || sol_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cand%0d: cand=%h tries=%0d t=%b b=%b v=%b, want cand=%h tries=%0d t=0 b=1 v=0",
                     i, cand, tries, timeout, busy, sol_valid, model_cand(), i);
         end
         // a start arriving mid-search must be ignored
         start = (i == 8);
         seed  = 64'hFFFF_0000;
         tick();
         model_adv();
      end
      start = 1'b0;
      n_tests++;
      if (timeout !== 1'b1 || busy !== 1'b0 || tries !== 32'd16 || sol_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: t=%b b=%b tries=%0d v=%b, want 1 0 16 0", timeout, busy, tries, sol_valid);
      end
      tick();
      n_tests++;
      if (timeout !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_once: t=%b d=%b, want 0 0", timeout, done);
      end
   endtask

   task automatic test_backpressure();
      logic [CW-1:0] exp_c;
      sol_ready = 1'b0;
      start_run(64'h0BAD_F00D, 16'd1);
      for (int i = 0; i < 5; i++) begin
         sat = (i == 4);
         if (i < 4) begin
            tick();
            model_adv();
         end else begin
            tick();
         end
      end
      sat   = 1'b0;
      exp_c = model_cand();
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (sol_valid !== 1'b1 || sol_data !== exp_c || cand !== exp_c || tries !== 32'd4) begin
            n_fail++;
            $display("FAIL bp_hold%0d: v=%b data=%h cand=%h tries=%0d, want v=1 data=cand=%h tries=4",
                     i, sol_valid, sol_data, cand, tries, exp_c);
         end
         tick();
      end
      sol_ready = 1'b1;
      n_tests++;
      if (sol_valid !== 1'b1 || tries !== 32'd4) begin
         n_fail++;
         $display("FAIL bp_pre_hs: v=%b tries=%0d, want 1 4", sol_valid, tries);
      end
      tick();
      sol_ready = 1'b0;
      n_tests++;
      if (sol_valid !== 1'b0 || tries !== 32'd0 || done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_post_hs: v=%b tries=%0d done=%b busy=%b, want 0 0 1 0", sol_valid, tries, done, busy);
      end
   endtask

   task automatic test_zero_seed_stop_search();
      sat = 1'b0;
      start_run(64'h0, 16'd0);
      n_tests++;
      if (cand[63:0] !== 64'h1 || cand[127:64] !== 64'h9E37_79B9_7F4A_7C15 || cand[129:128] !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_seed_first: cand=%h, want lane0=1 lane1=9e3779b97f4a7c15 top=2", cand);
      end
      tick();
      n_tests++;
      if (cand[63:0] !== 64'hD800_0000_0000_0000) begin
         n_fail++;
         $display("FAIL zero_seed_second: lane0=%h, want d800000000000000", cand[63:0]);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || sol_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_search: done=%b busy=%b v=%b, want 1 0 0", done, busy, sol_valid);
      end
   endtask

   task automatic test_stop_hold();
      sat = 1'b1; sol_ready = 1'b0;
      start_run(64'h55, 16'd0);
      tick();
      sat  = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (sol_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || sol_data !== model_cand()) begin
            n_fail++;
            $display("FAIL stop_hold%0d: v=%b busy=%b done=%b data=%h, want 1 1 0 %h",
                     i, sol_valid, busy, done, sol_data, model_cand());
         end
         tick();
      end
      sol_ready = 1'b1;
      tick();
      sol_ready = 1'b0;
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || sol_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_hold_done: done=%b busy=%b v=%b, want 1 0 0", done, busy, sol_valid);
      end
   endtask

   task automatic run_to_third(output logic [CW-1:0] d);
      sol_ready = 1'b0;
      start_run(64'hBEEF, 16'd0);
      sat = 1'b0;
      tick(); model_adv();
      tick(); model_adv();
      sat = 1'b1;
      tick();
      sat = 1'b0;
      d = sol_data;
   endtask

   task automatic test_reset_mid_hold();
      logic [CW-1:0] first;
      logic [CW-1:0] second;
      run_to_third(first);
      n_tests++;
      if (sol_valid !== 1'b1 || first !== model_cand()) begin
         n_fail++;
         $display("FAIL rst_run1: v=%b data=%h, want 1 %h", sol_valid, first, model_cand());
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (sol_valid !== 1'b0 || busy !== 1'b0 || cand !== '0 || sol_data !== '0) begin
         n_fail++;
         $display("FAIL rst_async: v=%b busy=%b cand=%h data=%h, want all 0", sol_valid, busy, cand, sol_data);
      end
      tick();
      rst_n = 1'b1;
      run_to_third(second);
      n_tests++;
      if (second !== first || sol_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_rerun: data=%h v=%b, want %h 1", second, sol_valid, first);
      end
      stop = 1'b1; sol_ready = 1'b1;
      tick();
      stop = 1'b0; sol_ready = 1'b0;
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_rerun_done: done=%b busy=%b, want 1 0", done, busy);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; seed = '0; num_sol = '0;
      stop = 1'b0; sat = 1'b0; sol_ready = 1'b0;
      #12;
      test_reset();
      rst_n = 1'b1;
      test_stream();
      test_timeout();
      test_backpressure();
      test_zero_seed_stop_search();
      test_stop_hold();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
